dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Arbitrates the byte-wide data memory (datmem, 8-bit locations, big-endian words) between two word-level requesters: the processor load/store path and a debug/loader port. Each 32-bit access is sequenced as four byte beats on one shared memory port. Read data is reassembled and returned with a one-cycle ack. The block sits between the datapath's memread/memwrite/sum/datab signals and the memory array.

Parameters:
ADDR_W, 5, byte-address width; addresses wrap modulo 2^ADDR_W.
CPU_PRIORITY, 0, 0 = round-robin between requesters; 1 = CPU always wins ties.

Ports:
clk  input  1  system clock, all state on posedge
rst_n  input  1  asynchronous, active-low reset
cpu_req  input  1  CPU transaction request; held with fields stable until cpu_ack
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  byte address of the word MSB (bits 31:24)
cpu_wdata  input  32  write word
cpu_ack  output  1  one-cycle completion pulse
cpu_rdata  output  32  read word; valid while cpu_ack=1, held until next CPU read completes
dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata  (same directions, widths and meaning as the cpu_* ports)
mem_addr  output  ADDR_W  byte address to memory
mem_wdata  output  8  byte to write
mem_we  output  1  byte write strobe
mem_re  output  1  byte read strobe
mem_rdata  input  8  synchronous read data, valid the cycle after mem_re/mem_addr
busy  output  1  high in every non-IDLE state
owner  output  1  0 = CPU, 1 = debug; owner of the current or last transaction

Behaviour:
- Reset (asynchronous, immediate): state=IDLE. All outputs 0, including mem_we, mem_re, acks, rdata registers and owner. last_grant=1, so the CPU wins the first tie. Beat counter=0.
- Reset mid-transaction: bytes already written stay written (no rollback). No ack is issued. The requester must re-request.
- FSM states: IDLE, BEAT, TAIL, ACK.
- IDLE: on a posedge with any req high, pick the winner:
  - Only one req high: grant it.
  - Both high, CPU_PRIORITY=1: grant the CPU.
  - Both high, CPU_PRIORITY=0: grant the requester that is not last_grant.
  - On grant, latch we/addr/wdata, set owner and last_grant, cnt=0, go to BEAT.
- BEAT (4 cycles, cnt 0..3):
  - mem_addr = latched_addr + cnt, truncated to ADDR_W (wrap).
  - Write: mem_we=1, mem_wdata = word[31-8*cnt : 24-8*cnt].
  - Read: mem_re=1. The byte returned for beat cnt-1 is captured into the assembly register at bits [31-8*(cnt-1) : 24-8*(cnt-1)].
  - After cnt=3, go to TAIL.
- TAIL (1 cycle): mem_we=mem_re=0. For a read, capture the beat-3 byte into bits 7:0. Writes also pass through TAIL, so latency is uniform.
- ACK (1 cycle):
  - Pulse the owner's ack. For reads, load the owner's rdata register from the assembly register.
  - The other requester's rdata is unchanged. Write acks leave rdata unchanged.
  - Next state is IDLE.
- Latency: grant at edge E0; beats occupy cycles E1..E4; ack is high during cycle E6..E7. Every transaction is 6 cycles busy plus 1 ack cycle; the next grant is at earliest on the edge following ACK.
- Requests arriving while busy are neither lost nor acted on. They are sampled only in IDLE.
- Requester contract:
  - Fields must stay stable from req rise until ack.
  - After ack the requester either drops req or presents a new transaction in the following cycle. Holding req high is treated as a new request.
- mem_we and mem_re are never high together. Both are 0 outside BEAT.

Test Plan:
- CPU write 0xDEADBEEF to addr 4, dbg idle -> bytes 4..7 = DE,AD,BE,EF. cpu_ack is a single pulse 6 cycles after grant. busy is high for 6 cycles. dbg_ack stays 0.
- CPU read at addr 4 after the above -> cpu_rdata = 0xDEADBEEF with cpu_ack. mem_re is high for exactly 4 cycles with addresses 4,5,6,7.
- dbg write 0x11223344 at addr 30 -> memory bytes 30,31,0,1 = 11,22,33,44 (wrap). dbg read at addr 30 returns 0x11223344.
- CPU_PRIORITY=0, both reqs held high continuously -> grants alternate CPU, dbg, CPU, dbg, with CPU first after reset. With CPU_PRIORITY=1 and the same stimulus, dbg is never granted while cpu_req stays high.
- Reset asserted during a CPU write of 0xAABBCCDD at addr 8, after beats 0 and 1 -> bytes 8,9 = AA,BB and bytes 10,11 keep their old values. No ack. All outputs are 0 immediately. A subsequent request completes normally.
- dbg_req rises while a CPU transaction is busy -> dbg is granted on the first IDLE edge after cpu_ack. cpu_rdata is unchanged by the dbg transaction.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Signal bundle between the word-level requesters, the arbiter and the byte-wide data memory.
// The slave modport is the arbiter's view; the master modport is the view of requesters and memory.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 5
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_ack;
    logic [31:0]       cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_ack;
    logic [31:0]       dbg_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the byte-wide data memory: each 32-bit big-endian word access
// becomes four byte beats on the shared memory port, followed by a one-cycle ack.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int CPU_PRIORITY = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    dmem_port_arbiter_if.slave  bus,
    output logic                busy,
    output logic                owner
);
    typedef enum logic [1:0] {S_IDLE, S_BEAT, S_TAIL, S_ACK} state_t;

    state_t            r_state;
    logic [1:0]        r_cnt;
    logic              r_we;
    logic              r_owner;
    logic              r_last_grant;
    logic [31:0]       r_word;
    logic [31:0]       r_asm;
    logic [31:0]       r_cpu_rdata;
    logic [31:0]       r_dbg_rdata;
    logic              r_cpu_ack;
    logic              r_dbg_ack;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic              r_mem_we;
    logic              r_mem_re;

    logic              w_any_req;
    logic              w_grant_dbg;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;

    // Debug wins when alone, or on a tie in round-robin mode when the CPU had the last grant.
    assign w_any_req   = bus.cpu_req | bus.dbg_req;
    assign w_grant_dbg = bus.dbg_req & (~bus.cpu_req | ((CPU_PRIORITY == 0) & ~r_last_grant));
    assign w_sel_we    = w_grant_dbg ? bus.dbg_we    : bus.cpu_we;
    assign w_sel_addr  = w_grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
    assign w_sel_wdata = w_grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_word       <= '0;
            r_asm        <= '0;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
            r_cpu_ack    <= 1'b0;
            r_dbg_ack    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_dbg_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner      <= w_grant_dbg;
                        r_last_grant <= w_grant_dbg;
                        r_we         <= w_sel_we;
                        r_cnt        <= '0;
                        r_mem_addr   <= w_sel_addr;
                        r_mem_wdata  <= w_sel_wdata[31:24];
                        r_word       <= {w_sel_wdata[23:0], 8'h00};
                        r_mem_we     <= w_sel_we;
                        r_mem_re     <= ~w_sel_we;
                        r_state      <= S_BEAT;
                    end
                end
                S_BEAT: begin
                    // Read data lags the strobe by a cycle, so beat n-1 arrives during beat n.
                    if (r_cnt != 2'd0) begin
                        r_asm <= {r_asm[23:0], bus.mem_rdata};
                    end
                    if (r_cnt == 2'd3) begin
                        r_mem_we <= 1'b0;
                        r_mem_re <= 1'b0;
                        r_state  <= S_TAIL;
                    end else begin
                        r_cnt       <= r_cnt + 2'd1;
                        r_mem_addr  <= r_mem_addr + ADDR_W'(1);
                        r_mem_wdata <= r_word[31:24];
                        r_word      <= {r_word[23:0], 8'h00};
                    end
                end
                S_TAIL: begin
                    r_asm   <= {r_asm[23:0], bus.mem_rdata};
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    if (r_owner) begin
                        r_dbg_ack <= 1'b1;
                        if (!r_we) r_dbg_rdata <= r_asm;
                    end else begin
                        r_cpu_ack <= 1'b1;
                        if (!r_we) r_cpu_rdata <= r_asm;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign owner         = r_owner;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.dbg_ack   = r_dbg_ack;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.dbg_rdata = r_dbg_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_re    = r_mem_re;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: table of word transactions against a byte memory model,
// plus hand sequences for arbitration, reset mid-write and requests arriving while busy.
module tb_dmem_port_arbiter;
    localparam int AW = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(AW)) if0 ();
    dmem_port_arbiter_if #(.ADDR_W(AW)) if1 ();
    logic busy0, owner0, busy1, owner1;

    dmem_port_arbiter #(.ADDR_W(AW), .CPU_PRIORITY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave), .busy(busy0), .owner(owner0));
    dmem_port_arbiter #(.ADDR_W(AW), .CPU_PRIORITY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave), .busy(busy1), .owner(owner1));

    // The priority instance sees exactly the same requests as the round-robin one.
    assign if1.cpu_req   = if0.cpu_req;
    assign if1.cpu_we    = if0.cpu_we;
    assign if1.cpu_addr  = if0.cpu_addr;
    assign if1.cpu_wdata = if0.cpu_wdata;
    assign if1.dbg_req   = if0.dbg_req;
    assign if1.dbg_we    = if0.dbg_we;
    assign if1.dbg_addr  = if0.dbg_addr;
    assign if1.dbg_wdata = if0.dbg_wdata;

    logic [7:0] mem0 [32] = '{default: 8'h00};
    logic [7:0] mem1 [32] = '{default: 8'h00};

    always @(posedge clk) begin
        if (if0.mem_we) mem0[if0.mem_addr] <= if0.mem_wdata;
        if (if0.mem_re) if0.mem_rdata <= mem0[if0.mem_addr];
        if (if1.mem_we) mem1[if1.mem_addr] <= if1.mem_wdata;
        if (if1.mem_re) if1.mem_rdata <= mem1[if1.mem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("we_re_exclusive", 32'((if0.mem_we & if0.mem_re) | (if1.mem_we & if1.mem_re)), 32'd0);
    end

    function automatic logic [31:0] word0(input logic [AW-1:0] a);
        logic [AW-1:0] p;
        logic [31:0]   w;
        p = a;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            w = {w[23:0], mem0[p]};
            p = p + AW'(1);
        end
        return w;
    endfunction

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, 32'({busy0, owner0, if0.mem_we, if0.mem_re, if0.cpu_ack, if0.dbg_ack}), 32'd0);
        chk({name, "_memaddr"}, 32'(if0.mem_addr), 32'd0);
        chk({name, "_memwdata"}, 32'(if0.mem_wdata), 32'd0);
        chk({name, "_cpu_rdata"}, if0.cpu_rdata, 32'd0);
        chk({name, "_dbg_rdata"}, if0.dbg_rdata, 32'd0);
    endtask

    task automatic set_req(input bit who, input bit val);
        if (who) if0.dbg_req = val;
        else     if0.cpu_req = val;
    endtask

    // One complete transaction on dut0: grant on the next posedge, strobes checked per cycle.
    task automatic run_txn(input bit who, input bit we, input logic [AW-1:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata);
        int            lat, nbusy, nstb;
        logic [AW-1:0] ea;
        logic [31:0]   ws;
        lat = -1; nbusy = 0; nstb = 0; ea = addr; ws = wdata; rdata = '0;
        if (who) begin
            if0.dbg_we = we; if0.dbg_addr = addr; if0.dbg_wdata = wdata;
        end else begin
            if0.cpu_we = we; if0.cpu_addr = addr; if0.cpu_wdata = wdata;
        end
        set_req(who, 1'b1);
        @(posedge clk);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (busy0) nbusy++;
            if (if0.mem_re | if0.mem_we) begin
                nstb++;
                chk("beat_addr", 32'(if0.mem_addr), 32'(ea));
                chk("beat_dir", 32'({if0.mem_we, if0.mem_re}), we ? 32'd2 : 32'd1);
                if (we) chk("beat_wdata", 32'(if0.mem_wdata), 32'(ws[31:24]));
                ea = ea + AW'(1);
                ws = ws << 8;
            end
            chk("other_ack", 32'(who ? if0.cpu_ack : if0.dbg_ack), 32'd0);
            if (who ? if0.dbg_ack : if0.cpu_ack) begin
                lat   = c;
                rdata = who ? if0.dbg_rdata : if0.cpu_rdata;
                break;
            end
        end
        set_req(who, 1'b0);
        chk("ack_latency", lat, 32'd6);
        chk("busy_cycles", nbusy, 32'd6);
        chk("beat_count", nstb, 32'd4);
        @(negedge clk);
        chk("ack_single_pulse", 32'({if0.cpu_ack, if0.dbg_ack}), 32'd0);
        chk("idle_after_ack", 32'(busy0), 32'd0);
    endtask

    typedef struct {
        bit            who;
        bit            we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   exp;
    } vec_t;

    vec_t        vecs[7];
    logic [31:0] rd;
    logic [31:0] exp_cpu_rd;
    logic [31:0] exp_dbg_rd;
    bit          seq[$];
    int          n1c, n1d, lat;
    bit          got;

    initial begin
        // who, we, addr, wdata, expected (memory word for writes, rdata for reads)
        vecs[0] = '{1'b0, 1'b1, 5'd4,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 1'b0, 5'd4,  32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 5'd30, 32'h11223344, 32'h11223344};
        vecs[3] = '{1'b1, 1'b0, 5'd30, 32'h0,        32'h11223344};
        vecs[4] = '{1'b0, 1'b1, 5'd8,  32'h01020304, 32'h01020304};
        vecs[5] = '{1'b1, 1'b0, 5'd4,  32'h0,        32'hDEADBEEF};
        vecs[6] = '{1'b0, 1'b0, 5'd0,  32'h0,        32'h33440000};

        if0.cpu_req = 0; if0.cpu_we = 0; if0.cpu_addr = '0; if0.cpu_wdata = '0;
        if0.dbg_req = 0; if0.dbg_we = 0; if0.dbg_addr = '0; if0.dbg_wdata = '0;
        exp_cpu_rd = '0; exp_dbg_rd = '0;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset_idle");

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
            if (vecs[i].we) begin
                chk("mem_word", word0(vecs[i].addr), vecs[i].exp);
            end else begin
                chk("read_word", rd, vecs[i].exp);
                if (vecs[i].who) exp_dbg_rd = vecs[i].exp;
                else             exp_cpu_rd = vecs[i].exp;
            end
            chk("cpu_rdata_hold", if0.cpu_rdata, exp_cpu_rd);
            chk("dbg_rdata_hold", if0.dbg_rdata, exp_dbg_rd);
            chk("owner_after", 32'(owner0), 32'(vecs[i].who));
        end

        // Both requesters held high from reset: RR alternates starting with CPU; priority never serves dbg.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        if0.cpu_we = 0; if0.cpu_addr = 5'd4;
        if0.dbg_we = 0; if0.dbg_addr = 5'd30;
        if0.cpu_req = 1; if0.dbg_req = 1;
        n1c = 0; n1d = 0;
        for (int c = 0; c < 80 && seq.size() < 4; c++) begin
            @(negedge clk);
            if (if0.cpu_ack) begin
                seq.push_back(1'b0);
                chk("rr_cpu_rdata", if0.cpu_rdata, 32'hDEADBEEF);
            end
            if (if0.dbg_ack) begin
                seq.push_back(1'b1);
                chk("rr_dbg_rdata", if0.dbg_rdata, 32'h11223344);
            end
            if (if1.cpu_ack) n1c++;
            if (if1.dbg_ack) n1d++;
        end
        if0.cpu_req = 0; if0.dbg_req = 0;
        chk("rr_grant_count", seq.size(), 32'd4);
        for (int i = 0; i < seq.size(); i++) chk("rr_order", 32'(seq[i]), 32'(i % 2));
        chk("prio_dbg_acks", n1d, 32'd0);
        chk("prio_cpu_acks", n1c, 32'd4);
        repeat (3) @(negedge clk);

        // Reset after two write beats: first two bytes land, the rest keep old contents, no ack.
        if0.cpu_we = 1; if0.cpu_addr = 5'd8; if0.cpu_wdata = 32'hAABBCCDD; if0.cpu_req = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        if0.cpu_req = 0;
        #1 chk_all_zero("reset_midtxn");
        chk("mid_b8",  32'(mem0[8]),  32'hAA);
        chk("mid_b9",  32'(mem0[9]),  32'hBB);
        chk("mid_b10", 32'(mem0[10]), 32'h03);
        chk("mid_b11", 32'(mem0[11]), 32'h04);
        repeat (2) begin
            @(negedge clk);
            chk("no_ack_in_reset", 32'({if0.cpu_ack, if0.dbg_ack}), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(1'b0, 1'b1, 5'd8, 32'hAABBCCDD, rd);
        chk("rewrite_word", word0(5'd8), 32'hAABBCCDD);
        chk("rewrite_cpu_rdata", if0.cpu_rdata, 32'd0);

        // dbg request arrives mid-CPU read: held off, then granted on the first IDLE edge after cpu_ack.
        if0.cpu_we = 0; if0.cpu_addr = 5'd4; if0.cpu_req = 1;
        @(posedge clk);
        repeat (2) @(negedge clk);
        if0.dbg_we = 0; if0.dbg_addr = 5'd30; if0.dbg_req = 1;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            chk("busy_dbg_held_off", 32'({if0.dbg_ack, owner0}), 32'd0);
            if (if0.cpu_ack) begin
                got = 1;
                if0.cpu_req = 0;
                chk("busy_cpu_rdata", if0.cpu_rdata, 32'hDEADBEEF);
            end
        end
        chk("busy_cpu_ack_seen", 32'(got), 32'd1);
        @(negedge clk);
        chk("dbg_granted_next", 32'({owner0, busy0}), 32'd3);
        lat = -1;
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            if (if0.dbg_ack) begin
                lat = c;
                if0.dbg_req = 0;
                break;
            end
        end
        if0.dbg_req = 0;
        chk("dbg_ack_latency", lat, 32'd6);
        chk("dbg_rdata", if0.dbg_rdata, 32'h11223344);
        chk("cpu_rdata_unchanged", if0.cpu_rdata, 32'hDEADBEEF);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
